box_plotter_gen: RTL and testbench
==================================

Name: box_plotter_gen

Overview:
- Parametrised VGA rectangle plotter feeding the VGA adapter's pixel-write interface.
- Takes a latched X, Y and colour, then emits one pixel per clock over a BOX_W x BOX_H rectangle.
- Adds a filled or outline mode and clips pixels that fall off the screen edge.
- Also supports a full-screen clear to black; oDone signals completion of either operation.

Parameters:
- X_SCREEN_PIXELS, 160, screen width in pixels.
- Y_SCREEN_PIXELS, 120, screen height in pixels.
- X_W, 8, X coordinate width; also the width of iXY_Coord.
- Y_W, 7, Y coordinate width.
- COLOUR_W, 3, colour width.
- BOX_W, 4, rectangle width in pixels (>=1).
- BOX_H, 4, rectangle height in pixels (>=1).

Ports:
- iClock  in  1  system clock; all state changes on its rising edge.
- iResetn  in  1  asynchronous, active-low reset.
- iLoadX  in  1  level; latch iXY_Coord into the X register.
- iPlotBox  in  1  level; start a rectangle draw, latching Y from iXY_Coord[Y_W-1:0].
- iBlack  in  1  level; start a full-screen clear.
- iOutline  in  1  sampled with iPlotBox; 1 = outline only, 0 = filled.
- iColour  in  COLOUR_W  rectangle colour, sampled with iPlotBox.
- iXY_Coord  in  X_W  coordinate bus.
- oX  out  X_W  pixel X.
- oY  out  Y_W  pixel Y.
- oColour  out  COLOUR_W  pixel colour.
- oPlot  out  1  pixel write enable.
- oDone  out  1  high after an operation completes.

Behaviour:
- Reset: iResetn low immediately forces the following, whether idle or mid-operation, with no partial continuation:
  - state IDLE;
  - X register, Y register, colour register, outline flag and scan counters cleared to 0;
  - oX=0, oY=0, oColour=0, oPlot=0, oDone=0.
- All outputs are registered.
- States:
  - IDLE: accepts commands.
  - DRAW: rectangle scan in progress.
  - CLEAR: full-screen scan in progress.
- X load: iLoadX high on an edge in any state loads X register <= iXY_Coord. This does not affect a draw already running, which uses the X captured at start.
- Command acceptance (IDLE only):
  - iBlack has priority over iPlotBox when both are high.
  - iBlack -> CLEAR, scan counters set to (0,0), oDone <= 0.
  - iPlotBox -> DRAW, with Y register <= iXY_Coord[Y_W-1:0], colour <= iColour, outline flag <= iOutline, counters (dx,dy) <= (0,0), oDone <= 0.
  - If iLoadX is high in the same cycle as iPlotBox, the X load occurs. The draw uses the previously latched X, because the start snapshot reads the register before update.
- Busy: iPlotBox and iBlack are ignored in DRAW and CLEAR. They are not queued.
- DRAW scan:
  - Row-major order: dx increments each cycle 0..BOX_W-1; on wrap, dx <= 0 and dy increments, up to BOX_H-1.
  - Each cycle registers oX = (Xs+dx)[X_W-1:0], oY = (Ys+dy)[Y_W-1:0], oColour = latched colour.
  - First pixel appears on outputs the cycle after the accepting edge.
- DRAW oPlot rule: oPlot = 1 only when all of the following hold:
  - on-screen: (Xs+dx) < X_SCREEN_PIXELS and (Ys+dy) < Y_SCREEN_PIXELS, with sums computed at X_W+1 and Y_W+1 bits so there is no wrap;
  - filled mode, or the position is on the border (dx==0, dx==BOX_W-1, dy==0 or dy==BOX_H-1).
- Scan duration: off-screen and interior-outline positions still consume a cycle, so a DRAW always lasts exactly BOX_W*BOX_H cycles.
- CLEAR: scans x 0..X_SCREEN_PIXELS-1 within y 0..Y_SCREEN_PIXELS-1, row-major, with oColour=0 and oPlot=1 every cycle. Duration is X_SCREEN_PIXELS*Y_SCREEN_PIXELS cycles.
- Completion: on the edge after the last scan position is output:
  - oPlot <= 0, state <= IDLE, oDone <= 1;
  - oX/oY hold their last values;
  - oDone stays high until the next accepted command or reset.
- Degenerate box: BOX_W=BOX_H=1 means one cycle of scan, and that single pixel is a border pixel.

Test Plan:
- Reset; iLoadX with 10; iPlotBox with Y=20, colour 5, iOutline=0 -> 16 consecutive oPlot=1 cycles covering (10..13, 20..23) row-major, oColour=5; oDone rises the next cycle and holds.
- Same draw with iOutline=1 -> 16 scan cycles; oPlot=0 exactly at (11,21), (12,21), (11,22), (12,22); the other 12 pixels plotted.
- X=158, Y=118 filled -> oPlot=1 only for x 158..159 and y 118..119 (4 pixels); duration still 16 cycles; oDone=1 afterwards.
- iBlack and iPlotBox high together in IDLE -> CLEAR runs 19200 cycles, oColour=0, oPlot=1 throughout, last pixel (159,119), then oDone=1; a pulse on iPlotBox mid-clear is ignored.
- Reset asserted asynchronously on the 6th pixel of a draw -> all outputs read 0 before the next clock edge; after release, with no command, oPlot stays 0 and oDone stays 0.
- iLoadX=30 pulsed during a running draw at X=10 -> remaining pixels still use X=10; the next iPlotBox draws at X=30.

Source files
------------

// File: rtl/box_plotter_gen.sv
// Rectangle / full-screen-clear pixel generator for the VGA adapter write port.
// Emits one registered pixel per clock; off-screen and outline-interior positions still take a cycle.
module box_plotter_gen #(
   parameter int X_SCREEN_PIXELS = 160,
   parameter int Y_SCREEN_PIXELS = 120,
   parameter int X_W             = 8,
   parameter int Y_W             = 7,
   parameter int COLOUR_W        = 3,
   parameter int BOX_W           = 4,
   parameter int BOX_H           = 4
) (
   input  logic                iClock,
   input  logic                iResetn,
   input  logic                iLoadX,
   input  logic                iPlotBox,
   input  logic                iBlack,
   input  logic                iOutline,
   input  logic [COLOUR_W-1:0] iColour,
   input  logic [X_W-1:0]      iXY_Coord,
   output logic [X_W-1:0]      oX,
   output logic [Y_W-1:0]      oY,
   output logic [COLOUR_W-1:0] oColour,
   output logic                oPlot,
   output logic                oDone
);
   typedef enum logic [1:0] {IDLE, DRAW, CLEAR} state_t;

   localparam logic [X_W-1:0] BXL = X_W'(BOX_W-1);
   localparam logic [Y_W-1:0] BYL = Y_W'(BOX_H-1);
   localparam logic [X_W-1:0] SXL = X_W'(X_SCREEN_PIXELS-1);
   localparam logic [Y_W-1:0] SYL = Y_W'(Y_SCREEN_PIXELS-1);

   state_t              state, n_state;
   logic [X_W-1:0]      xreg, xs, n_xs, dx, n_dx, n_ox;
   logic [Y_W-1:0]      ys, n_ys, dy, n_dy, n_oy;
   logic [COLOUR_W-1:0] col, n_col, n_ocol;
   logic                outl, n_outl, fin, n_fin, n_plot, n_done;
   logic [X_W:0]        sx;
   logic [Y_W:0]        sy;
   logic                onscr, border;

   // extra bit keeps the on-screen test from wrapping
   assign sx     = {1'b0, xs} + {1'b0, dx};
   assign sy     = {1'b0, ys} + {1'b0, dy};
   assign onscr  = (sx < (X_W+1)'(X_SCREEN_PIXELS)) && (sy < (Y_W+1)'(Y_SCREEN_PIXELS));
   assign border = (dx == '0) || (dx == BXL) || (dy == '0) || (dy == BYL);

   always_ff @(posedge iClock or negedge iResetn) begin
      if (!iResetn) xreg <= '0;
      else if (iLoadX) xreg <= iXY_Coord;
   end

   always_ff @(posedge iClock or negedge iResetn) begin
      if (!iResetn) begin
         state <= IDLE;
         xs <= '0; ys <= '0; col <= '0; outl <= 1'b0;
         dx <= '0; dy <= '0; fin <= 1'b0;
         oX <= '0; oY <= '0; oColour <= '0; oPlot <= 1'b0; oDone <= 1'b0;
      end else begin
         state <= n_state;
         xs <= n_xs; ys <= n_ys; col <= n_col; outl <= n_outl;
         dx <= n_dx; dy <= n_dy; fin <= n_fin;
         oX <= n_ox; oY <= n_oy; oColour <= n_ocol; oPlot <= n_plot; oDone <= n_done;
      end
   end

   always_comb begin
      n_state = state;
      n_xs = xs; n_ys = ys; n_col = col; n_outl = outl;
      n_dx = dx; n_dy = dy; n_fin = fin;
      n_ox = oX; n_oy = oY; n_ocol = oColour; n_plot = 1'b0; n_done = oDone;
      case (state)
         IDLE: begin
            if (iBlack) begin
               n_state = CLEAR;
               n_dx = '0; n_dy = '0; n_fin = 1'b0; n_done = 1'b0;
            end else if (iPlotBox) begin
               n_state = DRAW;
               n_xs = xreg;  // pre-update value when iLoadX is also high
               n_ys = iXY_Coord[Y_W-1:0];
               n_col = iColour; n_outl = iOutline;
               n_dx = '0; n_dy = '0; n_fin = 1'b0; n_done = 1'b0;
            end
         end
         DRAW: begin
            if (fin) begin
               n_state = IDLE; n_fin = 1'b0; n_done = 1'b1;
            end else begin
               n_ox = sx[X_W-1:0];
               n_oy = sy[Y_W-1:0];
               n_ocol = col;
               n_plot = onscr && (!outl || border);
               if (dx == BXL) begin
                  n_dx = '0;
                  if (dy == BYL) n_fin = 1'b1;
                  else n_dy = dy + 1'b1;
               end else n_dx = dx + 1'b1;
            end
         end
         CLEAR: begin
            if (fin) begin
               n_state = IDLE; n_fin = 1'b0; n_done = 1'b1;
            end else begin
               n_ox = dx; n_oy = dy; n_ocol = '0; n_plot = 1'b1;
               if (dx == SXL) begin
                  n_dx = '0;
                  if (dy == SYL) n_fin = 1'b1;
                  else n_dy = dy + 1'b1;
               end else n_dx = dx + 1'b1;
            end
         end
         default: n_state = IDLE;
      endcase
   end
endmodule

// File: tb/tb_box_plotter_gen.sv
// Randomised self-checking bench for box_plotter_gen against a pixel-list reference model.
module tb_box_plotter_gen;
   logic       clk = 1'b0, rstn = 1'b0;
   logic       ldx = 1'b0, plot_box = 1'b0, black = 1'b0, outline = 1'b0;
   logic [2:0] colour = '0;
   logic [7:0] xy = '0;
   logic [7:0] ox;
   logic [6:0] oy;
   logic [2:0] ocol;
   logic       oplot, odone;
   int         ntest = 0, nfail = 0;
   int         mx = 0;   // model of the latched X register

   box_plotter_gen dut (
      .iClock(clk), .iResetn(rstn), .iLoadX(ldx), .iPlotBox(plot_box), .iBlack(black),
      .iOutline(outline), .iColour(colour), .iXY_Coord(xy),
      .oX(ox), .oY(oy), .oColour(ocol), .oPlot(oplot), .oDone(odone)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      ntest++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] pk(input int x, input int y, input int c, input int p);
      logic [7:0] xb;
      logic [6:0] yb;
      logic [2:0] cb;
      xb = 8'(x); yb = 7'(y); cb = 3'(c);
      return {13'd0, xb, yb, cb, p[0]};
   endfunction

   function automatic logic [31:0] obs();
      return {13'd0, ox, oy, ocol, oplot};
   endfunction

   // mode 0: load x first; 1: use latched X; 2: iLoadX together with iPlotBox; 3: reload newx mid-draw
   task automatic do_draw(input string tag, input int x, input int y, input int c, input int o,
                          input int mode, input int newx);
      int xs, bad;
      logic [31:0] exp [$];
      if (mode == 0) begin
         @(negedge clk); ldx = 1'b1; xy = 8'(x);
         @(negedge clk); ldx = 1'b0;
         mx = x;
      end
      xs = mx;
      @(negedge clk);
      plot_box = 1'b1; xy = 8'(y); colour = 3'(c); outline = o[0]; ldx = (mode == 2);
      @(negedge clk);
      plot_box = 1'b0; ldx = 1'b0;
      if (mode == 2) mx = y & 8'hFF;
      chk({tag, "_busy_done"}, {31'd0, odone}, 32'd0);
      for (int j = 0; j < 4; j++)
         for (int i = 0; i < 4; i++) begin
            int ex, ey, on, bd;
            ex = xs + i; ey = (y & 8'h7F) + j;
            on = (ex < 160) && (ey < 120);
            bd = (i == 0) || (i == 3) || (j == 0) || (j == 3);
            exp.push_back(pk(ex, ey, c, int'(on != 0 && (o == 0 || bd != 0))));
         end
      bad = 0;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         if (obs() !== exp[k]) begin
            bad++;
            if (bad == 1) $display("FAIL %s_px%0d got=%h exp=%h", tag, k, obs(), exp[k]);
         end
         if (mode == 3 && k == 3) begin ldx = 1'b1; xy = 8'(newx); end
         if (mode == 3 && k == 4) begin ldx = 1'b0; mx = newx; end
      end
      chk({tag, "_pixels"}, 32'(bad), 32'd0);
      @(negedge clk);
      chk({tag, "_done"}, {30'd0, odone, oplot}, 32'b10);
      chk({tag, "_hold"}, obs(), exp[15] & ~32'd1);
      @(negedge clk);
      chk({tag, "_done_hold"}, {31'd0, odone}, 32'd1);
   endtask

   initial begin
      int bad;
      repeat (3) @(negedge clk);
      chk("rst_out", obs(), 32'd0);
      chk("rst_done", {31'd0, odone}, 32'd0);
      rstn = 1'b1;
      @(negedge clk);
      chk("idle_plot", {31'd0, oplot}, 32'd0);

      do_draw("fill", 10, 20, 5, 0, 0, 0);
      do_draw("outl", 10, 20, 5, 1, 0, 0);
      do_draw("edge", 158, 118, 6, 0, 0, 0);
      do_draw("midx", 10, 40, 3, 0, 3, 30);
      do_draw("newx", 0, 50, 2, 1, 1, 0);
      do_draw("samecyc", 0, 60, 7, 0, 2, 0);
      do_draw("after_same", 0, 8, 1, 1, 1, 0);
      for (int r = 0; r < 10; r++) begin
         int rx, ry;
         rx = (r < 5) ? int'($urandom_range(150, 255)) : int'($urandom_range(0, 255));
         ry = (r < 5) ? int'($urandom_range(110, 127)) : int'($urandom_range(0, 127));
         do_draw($sformatf("rnd%0d", r), rx, ry, int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 1)), int'($urandom_range(0, 1)) * 3, int'($urandom_range(0, 255)));
      end

      // clear with both commands high; iPlotBox pulse mid-clear must be ignored
      @(negedge clk);
      black = 1'b1; plot_box = 1'b1; xy = 8'd3; colour = 3'd7;
      @(negedge clk);
      black = 1'b0; plot_box = 1'b0;
      chk("clr_start_done", {31'd0, odone}, 32'd0);
      bad = 0;
      for (int k = 0; k < 19200; k++) begin
         @(negedge clk);
         if (obs() !== pk(k % 160, k / 160, 0, 1)) begin
            bad++;
            if (bad == 1) $display("FAIL clr_px%0d got=%h exp=%h", k, obs(), pk(k % 160, k / 160, 0, 1));
         end
         if (k == 100) plot_box = 1'b1;
         if (k == 101) plot_box = 1'b0;
      end
      chk("clr_pixels", 32'(bad), 32'd0);
      chk("clr_last", obs(), pk(159, 119, 0, 1));
      @(negedge clk);
      chk("clr_done", {30'd0, odone, oplot}, 32'b10);

      // asynchronous reset on the 6th pixel of a draw
      @(negedge clk); ldx = 1'b1; xy = 8'd10;
      @(negedge clk); ldx = 1'b0; plot_box = 1'b1; xy = 8'd20; colour = 3'd5; outline = 1'b0;
      @(negedge clk); plot_box = 1'b0;
      repeat (6) @(negedge clk);
      chk("pre_rst_px6", obs(), pk(11, 21, 5, 1));
      #1 rstn = 1'b0;
      #1;
      chk("async_rst_out", obs(), 32'd0);
      chk("async_rst_done", {31'd0, odone}, 32'd0);
      @(negedge clk); rstn = 1'b1; mx = 0;
      bad = 0;
      repeat (5) begin
         @(negedge clk);
         if (oplot !== 1'b0 || odone !== 1'b0) bad++;
      end
      chk("post_rst_quiet", 32'(bad), 32'd0);
      do_draw("post_rst", 0, 100, 4, 1, 1, 0);

      $display("[TB] %0d tests run, %0d failed", ntest, nfail);
      $finish;
   end
endmodule
